// File: rtl/dma_pkg.sv
// dma_pkg: shared AXI constants, FSM encoding and helpers for the DMA read/write engines
package dma_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int AXI_4K_BYTES = 4096;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/dma_burst_gen.sv
// dma_burst_gen: next INCR burst length as min(remaining, MAX_BURST, beats to 4 KB) plus the follow-on address
module dma_burst_gen
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH:0]    remaining,
  output logic [8:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam int SB = clog2(DATA_WIDTH / 8);
  localparam int W = (LEN_WIDTH + 1 > 13) ? LEN_WIDTH + 1 : 13;
  logic [12:0] to_4k;
  logic [W-1:0] cap, len_w;
  always_comb begin
    to_4k = (13'(AXI_4K_BYTES) - {1'b0, addr[11:0]}) >> SB;
    cap = (W'(MAX_BURST) < W'(to_4k)) ? W'(MAX_BURST) : W'(to_4k);
    len_w = (W'(remaining) < cap) ? W'(remaining) : cap;
    len = 9'(len_w);
    next_addr = addr + (ADDR_WIDTH'(len) << SB);
  end
endmodule

// File: rtl/dma_read_engine.sv
// dma_read_engine: MM2S channel splitting one transfer into 4 KB-safe AXI4 bursts streamed out on AXI-Stream
module dma_read_engine
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  beats_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);
  localparam int SB = clog2(DATA_WIDTH / 8);
  localparam int OW = clog2(MAX_OUTSTANDING + 1);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [LEN_WIDTH:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] beats_q, beats_d, beat_q, beat_d;
  logic [OW-1:0] out_q, out_d;
  logic arvalid_q, arvalid_d, err_q, err_d, fin_q, fin_d, done_q, done_d;
  logic [8:0] len;
  logic go, ar_hs, r_hs, drained;
  dma_burst_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_burst_gen (
    .addr     (addr_q),
    .remaining(rem_q),
    .len      (len),
    .next_addr(next_addr)
  );
  assign go = state_q == ST_IDLE && start_i;
  assign ar_hs = arvalid_q && m_axi_arready;
  assign r_hs = m_axi_rvalid && m_axi_rready;
  assign drained = out_q == '0 && fin_q;
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset)
    if (m_axi_areset) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start_i ? ST_RUN : ST_IDLE;
      ST_RUN:   state_d = (rem_q == '0) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = drained ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    addr_d = addr_q;
    rem_d = rem_q;
    beats_d = beats_q;
    beat_d = beat_q;
    err_d = err_q;
    fin_d = fin_q;
    out_d = out_q + OW'(ar_hs) - OW'(r_hs && m_axi_rlast);
    arvalid_d = arvalid_q ? !m_axi_arready : (state_q == ST_RUN && rem_q != '0 && out_q < OW'(MAX_OUTSTANDING));
    done_d = state_q == ST_DRAIN && drained;
    if (go) begin
      addr_d = addr_i & ~ADDR_WIDTH'((1 << SB) - 1);
      rem_d = (LEN_WIDTH + 1)'(beats_i) + (LEN_WIDTH + 1)'(1);
      beats_d = beats_i;
      beat_d = '0;
      err_d = 1'b0;
      fin_d = 1'b0;
    end
    if (ar_hs) begin
      addr_d = next_addr;
      rem_d = rem_q - (LEN_WIDTH + 1)'(len);
    end
    if (r_hs) begin
      beat_d = beat_q + LEN_WIDTH'(1);
      err_d = err_q || m_axi_rresp == AXI_RESP_SLVERR || m_axi_rresp == AXI_RESP_DECERR;
      fin_d = fin_q || m_axis_tlast;
    end
  end
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset)
    if (m_axi_areset) begin
      addr_q <= '0;
      rem_q <= '0;
      beats_q <= '0;
      beat_q <= '0;
      out_q <= '0;
      arvalid_q <= 1'b0;
      err_q <= 1'b0;
      fin_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q <= rem_d;
      beats_q <= beats_d;
      beat_q <= beat_d;
      out_q <= out_d;
      arvalid_q <= arvalid_d;
      err_q <= err_d;
      fin_q <= fin_d;
      done_q <= done_d;
    end
  always_comb begin
    busy_o = state_q != ST_IDLE;
    done_o = done_q;
    error_o = err_q;
    m_axi_arvalid = arvalid_q;
    m_axi_araddr = arvalid_q ? addr_q : '0;
    m_axi_arlen = arvalid_q ? 8'(len - 9'd1) : 8'd0;
    m_axi_arsize = 3'(SB);
    m_axi_arburst = AXI_BURST_INCR;
    m_axi_arcache = 4'b0011;
    m_axi_arprot = 3'b000;
    m_axi_rready = m_axis_tready && state_q != ST_IDLE;
    m_axis_tdata = m_axi_rdata;
    m_axis_tvalid = m_axi_rvalid && state_q != ST_IDLE;
    m_axis_tlast = state_q != ST_IDLE && beat_q == beats_q;
  end
endmodule

// File: tb/tb_dma_read_engine.sv
// tb_dma_read_engine: randomized memory slave plus reference transfer model driving directed steps
module tb_dma_read_engine;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic [3:0] m_axi_arcache;
  logic [2:0] m_axi_arprot;
  logic m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0] m_axi_rresp;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic start_i;
  logic [31:0] addr_i;
  logic [15:0] beats_i;
  logic busy_o, done_o, error_o;
  int checks = 0;
  int errors = 0;
  logic ar_rand = 1'b0;
  logic r_en = 1'b1;
  logic rv_rand = 1'b0;
  logic tr_rand = 1'b0;
  int err_idx = -1;
  logic [31:0] ar_addr_log[$];
  int ar_len_log[$];
  logic [63:0] st_data_log[$];
  logic st_last_log[$];
  logic [31:0] pend_addr[$];
  logic pend_last[$];
  int done_cnt = 0;
  int out_m = 0;
  int max_out = 0;
  int xfer_beat = 0;
  int viol_path = 0;
  int viol_db = 0;
  int viol_err = 0;
  logic err_exp = 1'b0;
  logic r_held = 1'b0;
  always #5 clk = ~clk;
  dma_read_engine dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .start_i      (start_i),
    .addr_i       (addr_i),
    .beats_i      (beats_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );
  function automatic logic [63:0] dfun(input logic [31:0] a);
    return {a ^ 32'h5A5A_A5A5, a};
  endfunction
  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = tr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rst) begin
        pend_addr.delete();
        pend_last.delete();
        out_m = 0;
        err_exp = 1'b0;
      end
      if (!r_held) m_axi_rvalid = !rst && r_en && pend_addr.size() > 0 && (!rv_rand || $urandom_range(0, 2) != 0);
      if (m_axi_rvalid) begin
        m_axi_rdata = dfun(pend_addr[0]);
        m_axi_rlast = pend_last[0];
        m_axi_rresp = (xfer_beat == err_idx) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rdata = '0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
      end
      #1;
      r_held = 1'b0;
      if (!rst) begin
        if (m_axi_rready !== (m_axis_tready && busy_o) || m_axis_tvalid !== (m_axi_rvalid && busy_o)) viol_path++;
        if (done_o && busy_o) viol_db++;
        if (error_o !== err_exp) viol_err++;
        if (done_o) done_cnt++;
        if (start_i && !busy_o) begin
          err_exp = 1'b0;
          xfer_beat = 0;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          ar_addr_log.push_back(m_axi_araddr);
          ar_len_log.push_back(int'(m_axi_arlen));
          for (int i = 0; i <= int'(m_axi_arlen); i++) begin
            pend_addr.push_back(m_axi_araddr + 32'(8 * i));
            pend_last.push_back(i == int'(m_axi_arlen));
          end
          out_m++;
        end
        r_held = m_axi_rvalid && !m_axi_rready;
        if (m_axi_rvalid && m_axi_rready) begin
          st_data_log.push_back(m_axis_tdata);
          st_last_log.push_back(m_axis_tlast);
          if (m_axi_rresp[1]) err_exp = 1'b1;
          xfer_beat++;
          if (m_axi_rlast) out_m--;
          void'(pend_addr.pop_front());
          void'(pend_last.pop_front());
        end
        if (out_m > max_out) max_out = out_m;
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_xfer(input logic [31:0] a, input int b, input logic exp_err, input logic poke, input logic hold);
    logic [31:0] ea[$];
    int el[$];
    longint x;
    int rem, n, ar0, st0, d0;
    x = longint'(a) - longint'(a) % 8;
    rem = b + 1;
    while (rem > 0) begin
      n = rem < 16 ? rem : 16;
      if (n > int'((4096 - x % 4096) / 8)) n = int'((4096 - x % 4096) / 8);
      ea.push_back(32'(x));
      el.push_back(n);
      x += n * 8;
      rem -= n;
    end
    ar0 = ar_addr_log.size();
    st0 = st_data_log.size();
    d0 = done_cnt;
    if (hold) r_en = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    addr_i = a;
    beats_i = 16'(b);
    @(negedge clk);
    start_i = 1'b0;
    addr_i = 32'hFFFF_FFFF;
    beats_i = 16'hFFFF;
    #2;
    check("busy_after_start", busy_o, 1'b1);
    check("error_cleared_by_start", error_o, 1'b0);
    if (poke) begin
      @(negedge clk);
      start_i = 1'b1;
      addr_i = 32'hDEAD_0000;
      beats_i = 16'd3;
      @(negedge clk);
      start_i = 1'b0;
    end
    if (hold) begin
      repeat (40) @(negedge clk);
      #2;
      check("ar_count_at_limit", 64'(ar_addr_log.size() - ar0), 64'd4);
      check("arvalid_held_low", m_axi_arvalid, 1'b0);
      r_en = 1'b1;
    end
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("busy_after_done", busy_o, 1'b0);
    check("error_after_done", error_o, exp_err);
    check("ar_count", 64'(ar_addr_log.size() - ar0), 64'(ea.size()));
    for (int i = 0; i < ea.size() && ar0 + i < ar_addr_log.size(); i++) begin
      check("ar_addr", ar_addr_log[ar0 + i], 64'(ea[i]));
      check("ar_len", 64'(ar_len_log[ar0 + i]), 64'(el[i] - 1));
    end
    check("beat_count", 64'(st_data_log.size() - st0), 64'(b + 1));
    for (int i = 0; i <= b && st0 + i < st_data_log.size(); i++) begin
      check("beat_data", st_data_log[st0 + i], dfun(32'(longint'(a) - longint'(a) % 8 + 8 * i)));
      check("beat_tlast", st_last_log[st0 + i], i == b);
    end
  endtask
  initial begin
    logic [31:0] ra;
    int ar0;
    rst = 1'b1;
    start_i = 1'b0;
    addr_i = '0;
    beats_i = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_arlen", m_axi_arlen, 64'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("arsize", m_axi_arsize, 64'd3);
    check("arburst", m_axi_arburst, 64'd1);
    check("arcache", m_axi_arcache, 64'd3);
    check("arprot", m_axi_arprot, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ar0 = ar_addr_log.size();
    run_xfer(32'h0000_1000, 63, 1'b0, 1'b1, 1'b0);
    check("t1_ar1", ar_addr_log[ar0 + 1], 64'h1080);
    check("t1_ar3", ar_addr_log[ar0 + 3], 64'h1180);
    ar0 = ar_addr_log.size();
    run_xfer(32'h0000_0FF0, 7, 1'b0, 1'b0, 1'b0);
    check("t2_ar0_addr", ar_addr_log[ar0], 64'h0FF0);
    check("t2_ar0_len", 64'(ar_len_log[ar0]), 64'd1);
    check("t2_ar1_addr", ar_addr_log[ar0 + 1], 64'h1000);
    check("t2_ar1_len", 64'(ar_len_log[ar0 + 1]), 64'd5);
    run_xfer(32'h0000_3000, 127, 1'b0, 1'b0, 1'b1);
    check("max_outstanding", 64'(max_out), 64'd4);
    ar_rand = 1'b1;
    rv_rand = 1'b1;
    tr_rand = 1'b1;
    run_xfer($urandom & 32'h000F_FFF8, 99, 1'b0, 1'b0, 1'b0);
    run_xfer(32'h0000_2000, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(32'h0000_2FFB, 0, 1'b0, 1'b0, 1'b0);
    err_idx = 3;
    run_xfer(32'h0000_5000, 15, 1'b1, 1'b0, 1'b0);
    err_idx = -1;
    for (int k = 0; k < 6; k++) begin
      ra = $urandom & 32'h000F_FFFF;
      run_xfer(ra, int'($urandom_range(0, 300)), 1'b0, 1'b0, 1'b0);
    end
    ar_rand = 1'b0;
    rv_rand = 1'b0;
    tr_rand = 1'b0;
    ar0 = ar_addr_log.size();
    @(negedge clk);
    start_i = 1'b1;
    addr_i = 32'h0000_6000;
    beats_i = 16'd63;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 200 && ar_addr_log.size() < ar0 + 2; i++) @(negedge clk);
    check("second_burst_issued", 64'(ar_addr_log.size() - ar0 >= 2), 64'd1);
    rst = 1'b1;
    #2;
    check("abort_busy", busy_o, 1'b0);
    check("abort_arvalid", m_axi_arvalid, 1'b0);
    check("abort_araddr", m_axi_araddr, 64'd0);
    check("abort_tvalid", m_axis_tvalid, 1'b0);
    check("abort_rready", m_axi_rready, 1'b0);
    check("abort_tlast", m_axis_tlast, 1'b0);
    check("abort_done", done_o, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_xfer(32'h0000_6000, 63, 1'b0, 1'b0, 1'b0);
    check("path_mirror_violations", 64'(viol_path), 64'd0);
    check("done_with_busy_violations", 64'(viol_db), 64'd0);
    check("error_tracking_violations", 64'(viol_err), 64'd0);
    check("max_outstanding_final", 64'(max_out), 64'd4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
